// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and default 100 MHz timing for the debouncer bank
package debounce_pkg;
    typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} state_t;
    localparam int DEF_STABLE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, stable-window filter, edge pulses and optional auto-repeat
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic rep
);
    localparam int CW = $clog2(STABLE_CYCLES);
    logic [1:0]    sync;
    logic          s;
    logic          lvl;
    state_t        state;
    logic [CW-1:0] cnt;
    assign s   = sync[1];
    assign lvl = (state == HIGH) || (state == WAIT_LO);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            state <= LOW;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            db   <= lvl;
            rise <= lvl & ~db;
            fall <= ~lvl & db;
            case (state)
                LOW: if (s) begin
                    state <= WAIT_HI;
                    cnt   <= CW'(1);
                end
                WAIT_HI: if (!s) begin
                    state <= LOW;
                    cnt   <= '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state <= HIGH;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
                HIGH: if (!s) begin
                    state <= WAIT_LO;
                    cnt   <= CW'(1);
                end
                WAIT_LO: if (s) begin
                    state <= HIGH;
                    cnt   <= '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state <= LOW;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
            endcase
        end
    end
    if (REPEAT_EN) begin : g_rep
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX);
        logic [RW-1:0] rcnt;
        logic          first;
        logic          term;
        assign term = rcnt == (first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
        // lvl drops one cycle before db, so the fall cycle never carries a repeat
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rcnt  <= '0;
                first <= 1'b0;
                rep   <= 1'b0;
            end else if (lvl && !db) begin
                rcnt  <= '0;
                first <= 1'b1;
                rep   <= 1'b1;
            end else if (lvl) begin
                rcnt  <= term ? '0 : rcnt + RW'(1);
                first <= first & ~term;
                rep   <= term;
            end else begin
                rcnt  <= '0;
                first <= 1'b0;
                rep   <= 1'b0;
            end
        end
    end else begin : g_norep
        assign rep = 1'b0;
    end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounce channels with per-channel auto-repeat enable
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int              N_CH          = 8,
    parameter int              STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int              REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int              REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter logic [N_CH-1:0] REPEAT_MASK   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] rep
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .db   (db[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .rep  (rep[i])
        );
    end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of press, bounce, repeat, glitch, simultaneity and reset abort
module tb_debounce_bank;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] raw = '0;
    logic [3:0] db, rise, fall, rep;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_rise;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH(4), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_MASK(4'b0011)
    ) dut (
        .clk(clk), .reset(reset), .raw(raw), .db(db), .rise(rise), .fall(fall), .rep(rep)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
        check("idle", {db, rise, fall, rep}, '0);
    endtask

    initial begin
        tick();
        tick();
        check("reset_outs", {db, rise, fall, rep}, '0);
        reset = 1'b1;
        settle(4);

        raw[2] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("press_db", db[2], e >= 6);
            check("press_rise", rise[2], e == 6);
            check("press_rep", rep[2], 1'b0);
        end
        raw[2] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("release_db", db[2], e < 6);
            check("release_fall", fall[2], e == 6);
        end
        settle(4);

        n_rise = 0;
        raw[3] = 1'b1;
        for (int e = 0; e < 22; e++) begin
            tick();
            check("bounce_db", db[3], e >= 14);
            n_rise += int'(rise[3]);
            raw[3] = (e + 1 < 8) ? (((e + 1) & 2) == 0) : 1'b1;
        end
        check("bounce_nrise", n_rise, 1);
        raw[3] = 1'b0;
        settle(12);

        raw[0] = 1'b1;
        for (int e = 0; e < 46; e++) begin
            tick();
            check("rep_db", db[0], e >= 6 && e < 37);
            check("rep_pulse", rep[0], e == 6 || (e >= 16 && e <= 34 && (e - 16) % 3 == 0));
            check("rep_fall", fall[0], e == 37);
            if (e == 30) raw[0] = 1'b0;
        end
        settle(4);

        raw[1] = 1'b1;
        for (int e = 0; e < 14; e++) begin
            tick();
            check("glitch", {db[1], rise[1], fall[1], rep[1]}, '0);
            if (e == 2) raw[1] = 1'b0;
        end

        raw = 4'b0101;
        for (int e = 0; e < 9; e++) begin
            tick();
            check("simul_rise", rise, e == 6 ? 4'b0101 : 4'b0000);
            check("simul_rep", rep, e == 6 ? 4'b0001 : 4'b0000);
        end
        raw = 4'b0000;
        settle(20);

        raw[1] = 1'b1;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (e == 4 || e == 5) check("rst_hold", {db, rise, fall, rep}, '0);
            check("rst_db", db[1], e >= 12);
            check("rst_rise", rise[1], e == 12);
            check("rst_rep", rep[1], e == 12);
            if (e == 4) begin
                reset = 1'b0;
                #1;
                check("rst_async", {db, rise, fall, rep}, '0);
            end
            if (e == 5) reset = 1'b1;
        end
        raw[1] = 1'b0;
        settle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
